store_queue: RTL and testbench

//  Holds executed stores (addr/data/strb) in program order until the ROB commits them, then

---
 rtl/store_queue_if.sv | 27 ++
 rtl/store_queue.sv | 192 +++++++++++++++++++
 tb/tb_store_queue.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_queue_if.sv
// Data-cache write port of the store queue: req/addr_ok/data_ok handshake plus write fault status.
// master = store queue side (issues writes), slave = data cache side.
interface store_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic                  data_ex;
    logic [4:0]            data_exccode;
    logic                  data_tlb_refill;

    modport master (
        output data_req, data_wr, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_ex, data_exccode, data_tlb_refill
    );

    modport slave (
        input  data_req, data_wr, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_ex, data_exccode, data_tlb_refill
    );
endinterface

// File: rtl/store_queue.sv
// In-order store queue: buffers executed stores and writes the head entry to the dcache on commit.
// Define STORE_QUEUE_FWD_EN to add the store-to-load forwarding lookup port.
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                sq_enq_valid,
    input  logic [ADDR_W-1:0]   sq_enq_addr,
    input  logic [DATA_W-1:0]   sq_enq_data,
    input  logic [DATA_W/8-1:0] sq_enq_strb,
    output logic                sq_allowin,
    input  logic                commit_store_valid,
    output logic                commit_store_ready,
    output logic [ADDR_W+6:0]   commit_store_ex,
    store_queue_if.master       dcache
`ifdef STORE_QUEUE_FWD_EN
    ,
    input  logic [ADDR_W-1:0]   fwd_addr,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [DATA_W/8-1:0] fwd_strb
`endif
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN_REQ, S_DRAIN_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
    logic [ADDR_W-1:0]   mem_addr_d [DEPTH];
    logic [DATA_W-1:0]   mem_data_q [DEPTH];
    logic [DATA_W-1:0]   mem_data_d [DEPTH];
    logic [STRB_W-1:0]   mem_strb_q [DEPTH];
    logic [STRB_W-1:0]   mem_strb_d [DEPTH];

    logic                data_req_q, data_req_d;
    logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
    logic [DATA_W-1:0]   data_wdata_q, data_wdata_d;
    logic [STRB_W-1:0]   data_wstrb_q, data_wstrb_d;
    logic                ready_q, ready_d;
    logic [ADDR_W+6:0]   ex_q, ex_d;

    logic full, draining, enq_fire, pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign draining   = (state_q == S_DRAIN_REQ) || (state_q == S_DRAIN_WAIT);
    assign sq_allowin = !full && !draining;
    assign enq_fire   = sq_enq_valid && sq_allowin && !flush;
    assign pop        = (state_q == S_DONE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        valid_d      = valid_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_strb_d   = mem_strb_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wstrb_d = data_wstrb_q;
        ex_d         = '0;

        unique case (state_q)
            S_IDLE:       if (count_q != '0 && commit_store_valid && !flush) state_d = S_REQ;
            S_REQ:        if (dcache.data_addr_ok) state_d = dcache.data_data_ok ? S_DONE : S_WAIT;
            S_WAIT:       if (dcache.data_data_ok) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            S_DRAIN_REQ:  if (dcache.data_addr_ok) state_d = dcache.data_data_ok ? S_IDLE : S_DRAIN_WAIT;
            S_DRAIN_WAIT: if (dcache.data_data_ok) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase

        // A flush during an in-flight write must still finish the handshake, but never report it.
        if (flush && state_q == S_REQ) begin
            if (!dcache.data_addr_ok)      state_d = S_DRAIN_REQ;
            else if (!dcache.data_data_ok) state_d = S_DRAIN_WAIT;
            else                           state_d = S_IDLE;
        end else if (flush && state_q == S_WAIT) begin
            state_d = dcache.data_data_ok ? S_IDLE : S_DRAIN_WAIT;
        end

        if (state_q == S_IDLE && state_d == S_REQ) begin
            data_addr_d  = mem_addr_q[head_q];
            data_wdata_d = mem_data_q[head_q];
            data_wstrb_d = mem_strb_q[head_q];
        end

        if (state_d == S_DONE && state_q != S_DONE && dcache.data_ex)
            ex_d = {1'b1, dcache.data_exccode, mem_addr_q[head_q], dcache.data_tlb_refill};

        if (enq_fire) begin
            mem_addr_d[tail_q] = sq_enq_addr;
            mem_data_d[tail_q] = sq_enq_data;
            mem_strb_d[tail_q] = sq_enq_strb;
            valid_d[tail_q]    = 1'b1;
            tail_d             = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(enq_fire) - CNT_W'(pop);

        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        data_req_d = (state_d == S_REQ) || (state_d == S_DRAIN_REQ);
        ready_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q      <= S_IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            data_req_q   <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            data_wstrb_q <= '0;
            ready_q      <= 1'b0;
            ex_q         <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            data_req_q   <= data_req_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            data_wstrb_q <= data_wstrb_d;
            ready_q      <= ready_d;
            ex_q         <= ex_d;
        end
    end

    // NOTE: entry payloads are not reset; the valid bits alone decide whether an entry means anything.
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_data_q <= mem_data_d;
        mem_strb_q <= mem_strb_d;
    end

    assign commit_store_ready = ready_q;
    assign commit_store_ex    = ex_q;
    assign dcache.data_req    = data_req_q;
    assign dcache.data_wr     = data_req_q;
    assign dcache.data_addr   = data_addr_q;
    assign dcache.data_wdata  = data_wdata_q;
    assign dcache.data_wstrb  = data_wstrb_q;

`ifdef STORE_QUEUE_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest from head so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_strb = '0;
        fwd_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (valid_q[fwd_idx] && mem_addr_q[fwd_idx][ADDR_W-1:2] == fwd_addr[ADDR_W-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[fwd_idx];
                fwd_strb = mem_strb_q[fwd_idx];
            end
        end
    end
`endif
endmodule

// File: tb/tb_store_queue.sv
// Directed self-checking bench for store_queue: issue latency, full/wrap, stalls, faults, flush, reset.
// Define STORE_QUEUE_FWD_EN to also exercise the forwarding lookup.
module tb_store_queue;
    logic        clk = 1'b0;
    logic        reset, flush;
    logic        sq_enq_valid;
    logic [31:0] sq_enq_addr, sq_enq_data;
    logic [3:0]  sq_enq_strb;
    logic        sq_allowin;
    logic        commit_store_valid, commit_store_ready;
    logic [38:0] commit_store_ex;
`ifdef STORE_QUEUE_FWD_EN
    logic [31:0] fwd_addr, fwd_data;
    logic        fwd_hit;
    logic [3:0]  fwd_strb;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    store_queue_if #(.ADDR_W(32), .DATA_W(32)) dc ();

    store_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .sq_enq_valid       (sq_enq_valid),
        .sq_enq_addr        (sq_enq_addr),
        .sq_enq_data        (sq_enq_data),
        .sq_enq_strb        (sq_enq_strb),
        .sq_allowin         (sq_allowin),
        .commit_store_valid (commit_store_valid),
        .commit_store_ready (commit_store_ready),
        .commit_store_ex    (commit_store_ex),
        .dcache             (dc.master)
`ifdef STORE_QUEUE_FWD_EN
        ,
        .fwd_addr           (fwd_addr),
        .fwd_hit            (fwd_hit),
        .fwd_data           (fwd_data),
        .fwd_strb           (fwd_strb)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        sq_enq_valid = 1'b1;
        sq_enq_addr  = a;
        sq_enq_data  = d;
        sq_enq_strb  = s;
        tick();
        sq_enq_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int w = 0;
        while (dc.data_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_req"}, 64'(dc.data_req), 64'd1);
    endtask

    // One complete write: addr_ok one cycle, data_ok the next; returns in the ready cycle.
    task automatic serve(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ex, input logic [4:0] code,
                         input logic refill);
        logic [38:0] exp_ex;
        exp_ex = ex ? {1'b1, code, a, refill} : 39'd0;
        wait_req(tag);
        chk({tag, "_addr"},  64'(dc.data_addr),  64'(a));
        chk({tag, "_wdata"}, 64'(dc.data_wdata), 64'(d));
        chk({tag, "_wstrb"}, 64'(dc.data_wstrb), 64'(s));
        chk({tag, "_wr"},    64'(dc.data_wr),    64'd1);
        dc.data_addr_ok = 1'b1;
        tick();
        dc.data_addr_ok = 1'b0;
        chk({tag, "_req_drop"}, 64'(dc.data_req), 64'd0);
        dc.data_data_ok    = 1'b1;
        dc.data_ex         = ex;
        dc.data_exccode    = code;
        dc.data_tlb_refill = refill;
        tick();
        dc.data_data_ok    = 1'b0;
        dc.data_ex         = 1'b0;
        dc.data_exccode    = 5'd0;
        dc.data_tlb_refill = 1'b0;
        chk({tag, "_ready"}, 64'(commit_store_ready), 64'd1);
        chk({tag, "_ex"},    64'(commit_store_ex),    64'(exp_ex));
    endtask

    logic [31:0] va [8];
    logic [31:0] vd [8];
    logic [3:0]  vs [8];
    int          nxt;

    initial begin
        reset = 1'b1; flush = 1'b0; sq_enq_valid = 1'b0;
        sq_enq_addr = '0; sq_enq_data = '0; sq_enq_strb = '0;
        commit_store_valid = 1'b0;
        dc.data_addr_ok = 1'b0; dc.data_data_ok = 1'b0; dc.data_ex = 1'b0;
        dc.data_exccode = 5'd0; dc.data_tlb_refill = 1'b0;
`ifdef STORE_QUEUE_FWD_EN
        fwd_addr = '0;
`endif
        tick(); tick();
        reset = 1'b0;
        chk("rst_req",     64'(dc.data_req),         64'd0);
        chk("rst_wr",      64'(dc.data_wr),          64'd0);
        chk("rst_addr",    64'(dc.data_addr),        64'd0);
        chk("rst_ready",   64'(commit_store_ready),  64'd0);
        chk("rst_ex",      64'(commit_store_ex),     64'd0);
        chk("rst_allowin", 64'(sq_allowin),          64'd1);

        // Single store, immediate handshake: req in cycle 1, ready in cycle 3.
        commit_store_valid = 1'b1;
        enq(32'h8000_0010, 32'hdead_beef, 4'hF);
        chk("t1_c0_req", 64'(dc.data_req), 64'd0);
        tick();
        chk("t1_c1_req", 64'(dc.data_req), 64'd1);
        chk("t1_addr",   64'(dc.data_addr),  64'h8000_0010);
        chk("t1_wdata",  64'(dc.data_wdata), 64'hdead_beef);
        chk("t1_wstrb",  64'(dc.data_wstrb), 64'hF);
        dc.data_addr_ok = 1'b1;
        tick();
        dc.data_addr_ok = 1'b0;
        chk("t1_c2_ready", 64'(commit_store_ready), 64'd0);
        dc.data_data_ok = 1'b1;
        tick();
        dc.data_data_ok = 1'b0;
        commit_store_valid = 1'b0;
        chk("t1_c3_ready", 64'(commit_store_ready), 64'd1);
        chk("t1_c3_ex",    64'(commit_store_ex),    64'd0);
        tick();
        chk("t1_c4_ready", 64'(commit_store_ready), 64'd0);

        // Fill, refuse the fifth, then drain eight stores across the pointer wrap.
        vs = '{4'hF, 4'h1, 4'h3, 4'hC, 4'h8, 4'h6, 4'hF, 4'h2};
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'h8000_0100 + 32'(4 * i);
            vd[i] = 32'ha000_0000 + 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            enq(va[i], vd[i], vs[i]);
            if (i == 2) chk("t2_allowin_3", 64'(sq_allowin), 64'd1);
        end
        chk("t2_full", 64'(sq_allowin), 64'd0);
        sq_enq_valid = 1'b1;
        sq_enq_addr = va[4]; sq_enq_data = vd[4]; sq_enq_strb = vs[4];
        tick();
        chk("t2_fifth_held", 64'(sq_allowin), 64'd0);
        commit_store_valid = 1'b1;
        nxt = 4;
        for (int i = 0; i < 8; i++) begin
            serve($sformatf("t2_s%0d", i), va[i], vd[i], vs[i], 1'b0, 5'd0, 1'b0);
            if (i == 0) chk("t2_full_in_done", 64'(sq_allowin), 64'd0);
            tick();
            if (i == 0) chk("t2_allowin_after_pop", 64'(sq_allowin), 64'd1);
            if (sq_enq_valid) begin
                tick();
                nxt++;
                if (nxt < 8) begin
                    sq_enq_addr = va[nxt]; sq_enq_data = vd[nxt]; sq_enq_strb = vs[nxt];
                end else begin
                    sq_enq_valid = 1'b0;
                end
            end
        end
        commit_store_valid = 1'b0;
        chk("t2_empty_idle_req", 64'(dc.data_req), 64'd0);

        // addr_ok delayed 5 cycles, data_ok 3 cycles later.
        commit_store_valid = 1'b1;
        enq(32'h8000_1230, 32'h1234_5678, 4'h6);
        wait_req("t3");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_hold%0d_req", k),  64'(dc.data_req),   64'd1);
            chk($sformatf("t3_hold%0d_addr", k), 64'(dc.data_addr),  64'h8000_1230);
            chk($sformatf("t3_hold%0d_data", k), 64'(dc.data_wdata), 64'h1234_5678);
            if (k < 5) tick();
        end
        dc.data_addr_ok = 1'b1;
        tick();
        dc.data_addr_ok = 1'b0;
        chk("t3_req_drop", 64'(dc.data_req), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("t3_wait%0d_ready", k), 64'(commit_store_ready), 64'd0);
        end
        dc.data_data_ok = 1'b1;
        tick();
        dc.data_data_ok = 1'b0;
        commit_store_valid = 1'b0;
        chk("t3_ready", 64'(commit_store_ready), 64'd1);
        tick();
        chk("t3_single_pulse", 64'(commit_store_ready), 64'd0);

        // Write fault reported with the ready pulse.
        commit_store_valid = 1'b1;
        enq(32'h0000_1000, 32'h5555_aaaa, 4'hF);
        serve("t4", 32'h0000_1000, 32'h5555_aaaa, 4'hF, 1'b1, 5'h01, 1'b0);
        chk("t4_ex_literal", 64'(commit_store_ex), 64'h42_0000_2000);
        commit_store_valid = 1'b0;
        tick();
        chk("t4_ex_clear", 64'(commit_store_ex), 64'd0);

        // Flush in WAIT with three entries.
        enq(32'h8000_0200, 32'hc000_0000, 4'hF);
        enq(32'h8000_0204, 32'hc000_0001, 4'hF);
        enq(32'h8000_0208, 32'hc000_0002, 4'hF);
        commit_store_valid = 1'b1;
        wait_req("t5");
        dc.data_addr_ok = 1'b1;
        tick();
        dc.data_addr_ok = 1'b0;
        commit_store_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_drain_allowin", 64'(sq_allowin), 64'd0);
        chk("t5_drain_ready",   64'(commit_store_ready), 64'd0);
        sq_enq_valid = 1'b1;
        sq_enq_addr = 32'h8000_0300; sq_enq_data = 32'hd00d_0001; sq_enq_strb = 4'h3;
        tick();
        chk("t5_drain_allowin2", 64'(sq_allowin), 64'd0);
        dc.data_data_ok = 1'b1;
        tick();
        dc.data_data_ok = 1'b0;
        chk("t5_no_ready",     64'(commit_store_ready), 64'd0);
        chk("t5_idle_allowin", 64'(sq_allowin),         64'd1);
        tick();
        sq_enq_valid = 1'b0;
        commit_store_valid = 1'b1;
        serve("t5_post", 32'h8000_0300, 32'hd00d_0001, 4'h3, 1'b0, 5'd0, 1'b0);
        commit_store_valid = 1'b0;
        tick();

        // Flush in REQ: request stays up until accepted, then no ready.
        commit_store_valid = 1'b1;
        enq(32'h8000_0400, 32'h0bad_f00d, 4'hF);
        wait_req("t5b");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        commit_store_valid = 1'b0;
        chk("t5b_drain_req",  64'(dc.data_req), 64'd1);
        tick();
        chk("t5b_drain_req2", 64'(dc.data_req), 64'd1);
        dc.data_addr_ok = 1'b1;
        tick();
        dc.data_addr_ok = 1'b0;
        chk("t5b_req_drop", 64'(dc.data_req), 64'd0);
        dc.data_data_ok = 1'b1;
        tick();
        dc.data_data_ok = 1'b0;
        chk("t5b_no_ready", 64'(commit_store_ready), 64'd0);
        chk("t5b_allowin",  64'(sq_allowin),         64'd1);

        // Reset in the middle of a request.
        commit_store_valid = 1'b1;
        enq(32'h8000_0500, 32'h7777_7777, 4'hF);
        wait_req("t7");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_rst_req",   64'(dc.data_req),        64'd0);
        chk("t7_rst_addr",  64'(dc.data_addr),       64'd0);
        chk("t7_rst_ready", 64'(commit_store_ready), 64'd0);
        tick(); tick();
        chk("t7_empty_req", 64'(dc.data_req), 64'd0);
        commit_store_valid = 1'b0;

`ifdef STORE_QUEUE_FWD_EN
        // Youngest matching store wins; other words miss.
        enq(32'h0000_0020, 32'h0000_1111, 4'h3);
        enq(32'h0000_0020, 32'h2222_0000, 4'hC);
        fwd_addr = 32'h0000_0022;
        #1;
        chk("t6_hit",  64'(fwd_hit),  64'd1);
        chk("t6_strb", 64'(fwd_strb), 64'hC);
        chk("t6_data", 64'(fwd_data), 64'h2222_0000);
        fwd_addr = 32'h0000_0024;
        #1;
        chk("t6_miss", 64'(fwd_hit), 64'd0);
        commit_store_valid = 1'b1;
        serve("t6_s0", 32'h0000_0020, 32'h0000_1111, 4'h3, 1'b0, 5'd0, 1'b0);
        serve("t6_s1", 32'h0000_0020, 32'h2222_0000, 4'hC, 1'b0, 5'd0, 1'b0);
        commit_store_valid = 1'b0;
        tick();
        fwd_addr = 32'h0000_0020;
        #1;
        chk("t6_empty_miss", 64'(fwd_hit), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
